// File: rtl/pad_mask_load_scheduler.sv
// Arbitrates the pad-mask RAM ports between host writes and serializer reloads,
// sequencing lane reloads lowest-index first and flagging lanes whose busy hangs.
module pad_mask_load_scheduler #(
  parameter int LANES         = 4,
  parameter int ADDR_WIDTH    = 9,
  parameter int DATA_WIDTH    = 8,
  parameter int TIMEOUT       = 1023,
  parameter int LOAD_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_all,
  input  logic [LANES-1:0]      load_req,
  input  logic                  host_wr_en,
  input  logic [1:0]            host_wr_lane,
  input  logic [ADDR_WIDTH-1:0] host_wr_addr,
  input  logic [DATA_WIDTH-1:0] host_wr_data,
  output logic                  host_wr_ack,
  output logic [LANES-1:0]      ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic [LANES-1:0]      host_owns,
  output logic [LANES-1:0]      start,
  input  logic [LANES-1:0]      busy,
  output logic [LANES-1:0]      pending,
  output logic                  sched_busy,
  output logic                  load_done,
  output logic [LANES-1:0]      timeout_err,
  input  logic                  err_clear
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [15:0] TMO = 16'(TIMEOUT);
  localparam logic [LANES-1:0] ALL_ONES = {LANES{1'b1}};
  localparam logic [LANES-1:0] PEND_RST = (LOAD_ON_RESET != 0) ? ALL_ONES : '0;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WRITE     = 3'd1,
    S_START     = 3'd2,
    S_WAIT_RISE = 3'd3,
    S_WAIT_FALL = 3'd4
  } state_t;

  function automatic logic [LANES-1:0] lane_onehot(input logic [LW-1:0] idx);
    logic [LANES-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  state_t                state_q, state_d;
  logic [LW-1:0]         cur_q, cur_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [LANES-1:0]      pending_q, pending_d;
  logic [LANES-1:0]      timeout_err_q, timeout_err_d;
  logic [LANES-1:0]      start_q, start_d;
  logic [LANES-1:0]      wr_sel_q, wr_sel_d;
  logic                  ack_q, ack_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  load_done_q, load_done_d;
  logic                  sched_busy_q, sched_busy_d;

  logic [LW-1:0]    first_s;
  logic [LANES-1:0] wr_onehot_s;
  logic [LANES-1:0] cur_onehot_s;
  logic [LANES-1:0] set_s;
  logic [LANES-1:0] clr_s;
  logic             finish_s;
  logic             tmo_s;

  // Next-state, pending bookkeeping and registered-output staging.
  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    cnt_d        = cnt_q;
    set_s        = '0;
    clr_s        = '0;
    finish_s     = 1'b0;
    tmo_s        = 1'b0;
    wr_onehot_s  = lane_onehot(LW'(host_wr_lane));
    cur_onehot_s = lane_onehot(cur_q);

    // Descending scan so the lowest set index wins.
    first_s = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      first_s = pending_q[i] ? LW'(i) : first_s;
    end

    case (state_q)
      S_IDLE: begin
        if (host_wr_en) begin
          state_d = S_WRITE;
        end else if (|pending_q) begin
          cur_d   = first_s;
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        set_s   = wr_onehot_s;
        state_d = S_IDLE;
      end
      S_START: begin
        cnt_d   = 16'd0;
        state_d = S_WAIT_RISE;
      end
      S_WAIT_RISE: begin
        if (busy[cur_q]) begin
          cnt_d   = 16'd0;
          state_d = S_WAIT_FALL;
        end else if (cnt_q == TMO) begin
          tmo_s    = 1'b1;
          finish_s = 1'b1;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_WAIT_FALL: begin
        if (!busy[cur_q]) begin
          finish_s = 1'b1;
          state_d  = S_IDLE;
        end else if (cnt_q == TMO) begin
          tmo_s    = 1'b1;
          finish_s = 1'b1;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (finish_s) begin
      clr_s = cur_onehot_s;
    end else begin
      clr_s = '0;
    end

    // A set and a clear landing together resolve to set, so the lane reloads again.
    set_s     = set_s | load_req | (load_all ? ALL_ONES : '0);
    pending_d = (pending_q & ~clr_s) | set_s;

    load_done_d = finish_s && (pending_d == '0);

    if (err_clear) begin
      timeout_err_d = '0;
    end else if (tmo_s) begin
      timeout_err_d = timeout_err_q | cur_onehot_s;
    end else begin
      timeout_err_d = timeout_err_q;
    end

    start_d      = (state_d == S_START) ? lane_onehot(cur_d) : '0;
    wr_sel_d     = (state_d == S_WRITE) ? wr_onehot_s : '0;
    ack_d        = (state_d == S_WRITE);
    addr_d       = (state_d == S_WRITE) ? host_wr_addr : addr_q;
    din_d        = (state_d == S_WRITE) ? host_wr_data : din_q;
    sched_busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cur_q         <= '0;
      cnt_q         <= 16'd0;
      pending_q     <= PEND_RST;
      timeout_err_q <= '0;
      start_q       <= '0;
      wr_sel_q      <= '0;
      ack_q         <= 1'b0;
      addr_q        <= '0;
      din_q         <= '0;
      load_done_q   <= 1'b0;
      sched_busy_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      cnt_q         <= cnt_d;
      pending_q     <= pending_d;
      timeout_err_q <= timeout_err_d;
      start_q       <= start_d;
      wr_sel_q      <= wr_sel_d;
      ack_q         <= ack_d;
      addr_q        <= addr_d;
      din_q         <= din_d;
      load_done_q   <= load_done_d;
      sched_busy_q  <= sched_busy_d;
    end
  end

  assign host_wr_ack = ack_q;
  assign ram_wea     = wr_sel_q;
  assign host_owns   = wr_sel_q;
  assign ram_addr    = addr_q;
  assign ram_din     = din_q;
  assign start       = start_q;
  assign pending     = pending_q;
  assign sched_busy  = sched_busy_q;
  assign load_done   = load_done_q;
  assign timeout_err = timeout_err_q;

endmodule
